pic_lit_core: RTL and testbench
===============================

PIC_LIT_CORE -- requirements
Module: pic_lit_core

Interface
REQ-001 Parameter DW, default 8: data/W-register width; literal field is ir[DW-1:0].
REQ-002 Parameter AW, default 8: program address width; AW SHALL be <= DW (elaboration error otherwise).
REQ-003 Derived IW = DW+6, default 14: instruction width; opcode is ir[IW-1:IW-6].
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 run  in  1  level enable; core fetches only while high.
REQ-007 rom_addr  out  AW  program ROM address, driven from MAR register.
REQ-008 rom_data  in  IW  ROM word; combinational, valid in the cycle after rom_addr changes.
REQ-009 w_q  out  DW  W register.
REQ-010 z_flag, c_flag  out  1 each  status flags.
REQ-011 pc_q  out  AW  program counter.
REQ-012 retire  out  1  one-cycle pulse in EXEC of every instruction, including HALT and illegal opcodes.
REQ-013 halted  out  1  high in HALT state; err  out  1  sticky, high after an illegal opcode.

Function
REQ-014 FSM states IDLE, FETCH, DECODE, EXEC, HALT; one instruction = 3 clocks (FETCH, DECODE, EXEC).
REQ-015 IDLE: stays while run=0; goes to FETCH when run=1.
REQ-016 FETCH: mar <= pc_q; goes to DECODE.
REQ-017 DECODE: ir <= rom_data; pc_q <= pc_q+1 mod 2^AW; goes to EXEC.
REQ-018 EXEC: apply opcode; goes to FETCH if run=1, IDLE if run=0; run is sampled only in IDLE and EXEC, so an instruction always completes once fetched.
REQ-019 Opcodes (k = ir[DW-1:0]): 0x00 NOP; 0x01 MOVLW W<=k; 0x02 ADDLW W<=k+W; 0x03 SUBLW W<=k-W; 0x04 ANDLW; 0x05 IORLW; 0x06 XORLW; 0x07 GOTO pc_q<=k[AW-1:0]; 0x08 SKPZ; 0x09 HALT.
REQ-020 Arithmetic is mod 2^DW; ADDLW sets C = carry-out of bit DW-1; SUBLW sets C = 1 when k >= W (no borrow), else 0.
REQ-021 ADDLW, SUBLW, ANDLW, IORLW, XORLW set Z = (result == 0); MOVLW, NOP, GOTO, SKPZ leave Z and C unchanged; logic ops leave C unchanged.
REQ-022 SKPZ: if Z=1, pc_q <= pc_q+1 mod 2^AW (skips the next word); otherwise no effect.
REQ-023 GOTO overrides the DECODE increment; a target equal to its own address is a legal tight loop.
REQ-024 HALT: goes to HALT state; halted=1; stays there until rst, regardless of run.
REQ-025 Illegal opcodes (0x0A-0x3F): W, flags and pc_q unchanged; err <= 1; behaves as HALT.
REQ-026 pc_q wraps 2^AW-1 -> 0 with no flag and no stall.

Reset
REQ-027 rst=1 at any clock edge, including mid-instruction or in HALT: state<=IDLE; pc_q, mar, ir, w_q <= 0; z_flag, c_flag, err, halted, retire <= 0.
REQ-028 rst takes priority over every other input; the partial instruction is discarded with no W or flag update.

Verification
REQ-029 ROM {MOVLW 0x05, ADDLW 0x03}, run=1 -> w_q=0x08 at 2nd retire; Z=0, C=0; retire pulses exactly 3 clocks apart.
REQ-030 MOVLW 0xFF; ADDLW 0x01 -> w_q=0x00, Z=1, C=1; then SKPZ at addr 2 -> word at addr 3 not executed, next fetch from addr 4.
REQ-031 MOVLW 0x10; SUBLW 0x08 -> w_q=0xF8, C=0; MOVLW 0x08; SUBLW 0x10 -> w_q=0x08, C=1.
REQ-032 GOTO 0xFF, with addr 0xFF = ADDLW 0x01 -> next fetch wraps to addr 0x00; pc_q=0x00.
REQ-033 Opcode 0x3F -> err=1, halted=1, w_q unchanged; toggling run changes nothing; rst -> all outputs return to 0.
REQ-034 rst pulsed in DECODE of ADDLW -> w_q stays at its prior value until the reset edge, then 0; with run=0 the core stays in IDLE.

Source files
------------

// File: rtl/pic_lit_core_if.sv
// Program ROM bus between the literal-only PIC core and its instruction store.
//
// Bus timing: rom_data is a pure combinational function of rom_addr. The core
// (master) holds rom_addr steady from a register and samples rom_data one clock
// after it has driven a new address; the ROM (slave) has no valid/ready
// handshake and never stalls the core.
interface pic_lit_core_if #(
    parameter int AW = 8,
    parameter int IW = 14
);
    logic [AW-1:0] rom_addr;
    logic [IW-1:0] rom_data;

    modport master (output rom_addr, input rom_data);
    modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/pic_lit_core.sv
// Small PIC-style core executing literal/W-register instructions from a ROM.
// Each instruction takes FETCH, DECODE and EXEC; the EXEC results become
// visible on w_q / flags / pc_q on the clock edge that ends EXEC.
module pic_lit_core #(
    parameter  int DW = 8,
    parameter  int AW = 8,
    localparam int IW = DW + 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    pic_lit_core_if.master rom,
    output logic [DW-1:0] w_q,
    output logic          z_flag,
    output logic          c_flag,
    output logic [AW-1:0] pc_q,
    output logic          retire,
    output logic          halted,
    output logic          err,
    output logic [2:0]    dbg_state
);

    // Program addresses are loaded from the literal field, so they must fit.
    if (AW > DW) begin : g_bad_aw
        $error("pic_lit_core: AW must not exceed DW");
    end

    localparam logic [5:0] OP_NOP   = 6'h00;
    localparam logic [5:0] OP_MOVLW = 6'h01;
    localparam logic [5:0] OP_ADDLW = 6'h02;
    localparam logic [5:0] OP_SUBLW = 6'h03;
    localparam logic [5:0] OP_ANDLW = 6'h04;
    localparam logic [5:0] OP_IORLW = 6'h05;
    localparam logic [5:0] OP_XORLW = 6'h06;
    localparam logic [5:0] OP_GOTO  = 6'h07;
    localparam logic [5:0] OP_SKPZ  = 6'h08;
    localparam logic [5:0] OP_HALT  = 6'h09;

    localparam logic [AW-1:0] PC_INC = AW'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    state_t        state;
    logic [AW-1:0] mar;
    logic [IW-1:0] ir;

    logic [5:0]    opcode;
    logic [DW-1:0] lit;
    logic [DW:0]   add_sum;
    logic [DW-1:0] alu_res;
    logic          alu_z;
    logic          alu_c;
    logic          wr_w;
    logic          wr_z;
    logic          wr_c;
    logic [AW-1:0] pc_exec;
    logic          is_halt;
    logic          is_illegal;

    assign opcode       = ir[IW-1:IW-6];
    assign lit          = ir[DW-1:0];
    assign rom.rom_addr = mar;
    assign dbg_state    = 3'(state);

    // Decode the latched instruction into W/flag/PC updates for EXEC.
    always_comb begin
        add_sum    = {1'b0, lit} + {1'b0, w_q};
        alu_res    = w_q;
        alu_c      = c_flag;
        wr_w       = 1'b0;
        wr_z       = 1'b0;
        wr_c       = 1'b0;
        pc_exec    = pc_q;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        case (opcode)
            OP_NOP: ;
            OP_MOVLW: begin
                alu_res = lit;
                wr_w    = 1'b1;
            end
            OP_ADDLW: begin
                alu_res = add_sum[DW-1:0];
                alu_c   = add_sum[DW];
                wr_w    = 1'b1;
                wr_z    = 1'b1;
                wr_c    = 1'b1;
            end
            OP_SUBLW: begin
                // C is "no borrow": set when the literal is at least W.
                alu_res = lit - w_q;
                alu_c   = (lit >= w_q);
                wr_w    = 1'b1;
                wr_z    = 1'b1;
                wr_c    = 1'b1;
            end
            OP_ANDLW: begin
                alu_res = lit & w_q;
                wr_w    = 1'b1;
                wr_z    = 1'b1;
            end
            OP_IORLW: begin
                alu_res = lit | w_q;
                wr_w    = 1'b1;
                wr_z    = 1'b1;
            end
            OP_XORLW: begin
                alu_res = lit ^ w_q;
                wr_w    = 1'b1;
                wr_z    = 1'b1;
            end
            OP_GOTO: begin
                // Replaces the increment already applied during DECODE.
                pc_exec = lit[AW-1:0];
            end
            OP_SKPZ: begin
                if (z_flag) begin
                    pc_exec = pc_q + PC_INC;
                end
            end
            OP_HALT: begin
                is_halt = 1'b1;
            end
            default: begin
                is_illegal = 1'b1;
            end
        endcase
        alu_z = (alu_res == '0);
    end

    // Sequencer: FETCH/DECODE/EXEC per instruction, run checked only in IDLE
    // and at the end of EXEC so a fetched instruction always completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            pc_q   <= '0;
            mar    <= '0;
            ir     <= '0;
            w_q    <= '0;
            z_flag <= 1'b0;
            c_flag <= 1'b0;
            err    <= 1'b0;
            halted <= 1'b0;
            retire <= 1'b0;
        end else begin
            retire <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (run) begin
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    mar   <= pc_q;
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    ir     <= rom.rom_data;
                    pc_q   <= pc_q + PC_INC;
                    retire <= 1'b1;
                    state  <= S_EXEC;
                end
                S_EXEC: begin
                    if (wr_w) begin
                        w_q <= alu_res;
                    end
                    if (wr_z) begin
                        z_flag <= alu_z;
                    end
                    if (wr_c) begin
                        c_flag <= alu_c;
                    end
                    pc_q <= pc_exec;
                    if (is_halt || is_illegal) begin
                        halted <= 1'b1;
                        state  <= S_HALT;
                        if (is_illegal) begin
                            err <= 1'b1;
                        end
                    end else if (run) begin
                        state <= S_FETCH;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pic_lit_core.sv
// Bench for pic_lit_core: table of short programs with expected final state,
// hand sequences for jump/halt/reset corners, and a randomized program run
// checked instruction by instruction against an architectural model.
module tb_pic_lit_core;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int IW = DW + 6;
    localparam int SW = DW + AW + 4;
    localparam int NV = 10;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic run = 1'b0;
    always #5 clk = ~clk;

    pic_lit_core_if #(.AW(AW), .IW(IW)) rom_bus ();
    logic [IW-1:0] rom_mem [0:(1<<AW)-1];
    assign rom_bus.rom_data = rom_mem[rom_bus.rom_addr];

    logic [DW-1:0] w_q;
    logic          z_flag, c_flag, retire, halted, err;
    logic [AW-1:0] pc_q;
    logic [2:0]    dbg_state;

    pic_lit_core #(.DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .rom       (rom_bus),
        .w_q       (w_q),
        .z_flag    (z_flag),
        .c_flag    (c_flag),
        .pc_q      (pc_q),
        .retire    (retire),
        .halted    (halted),
        .err       (err),
        .dbg_state (dbg_state)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- scoreboard / model ----------------
    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int n_ret = 0;
    int ret_cyc_last = 0;
    int ret_cyc_prev = 0;
    logic [SW-1:0] exp_q [$];
    bit pend = 0;

    logic [DW-1:0] m_w;
    logic          m_z, m_c, m_halted, m_err;
    logic [AW-1:0] m_pc;

    function automatic logic [IW-1:0] enc(input logic [5:0] op, input logic [7:0] k);
        return {op, k};
    endfunction

    function automatic logic [SW-1:0] pack(input logic [DW-1:0] w, input logic z, input logic c,
                                           input logic [AW-1:0] pc, input logic h, input logic e);
        return {w, z, c, pc, h, e};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_w = '0; m_z = 1'b0; m_c = 1'b0; m_pc = '0; m_halted = 1'b0; m_err = 1'b0;
        exp_q.delete();
        pend = 0;
    endtask

    // Executes the instruction at the model PC using plain arithmetic.
    task automatic model_step();
        logic [IW-1:0] ins;
        int op, k, wv, res;
        ins  = rom_mem[m_pc];
        op   = int'(ins[IW-1:IW-6]);
        k    = int'(ins[DW-1:0]);
        wv   = int'(m_w);
        m_pc = AW'((int'(m_pc) + 1) % 256);
        case (op)
            0: ;
            1: m_w = DW'(k);
            2: begin res = k + wv; m_c = (res > 255); m_w = DW'(res % 256); m_z = (m_w == 0); end
            3: begin m_c = (k >= wv); m_w = DW'((k - wv + 256) % 256); m_z = (m_w == 0); end
            4: begin m_w = DW'(k & wv); m_z = (m_w == 0); end
            5: begin m_w = DW'(k | wv); m_z = (m_w == 0); end
            6: begin m_w = DW'(k ^ wv); m_z = (m_w == 0); end
            7: m_pc = AW'(k);
            8: if (m_z) m_pc = AW'((int'(m_pc) + 1) % 256);
            9: m_halted = 1'b1;
            default: begin m_halted = 1'b1; m_err = 1'b1; end
        endcase
    endtask

    // One clock: compare last retired instruction's result, record new retires.
    task automatic step_cycle();
        @(negedge clk);
        cyc++;
        if (pend) begin
            check("arch_state", 32'(pack(w_q, z_flag, c_flag, pc_q, halted, err)), 32'(exp_q.pop_front()));
            pend = 0;
        end
        if (retire) begin
            n_ret++;
            ret_cyc_prev = ret_cyc_last;
            ret_cyc_last = cyc;
            check("fetch_addr", 32'(rom_bus.rom_addr), 32'(m_pc));
            model_step();
            exp_q.push_back(pack(m_w, m_z, m_c, m_pc, m_halted, m_err));
            pend = 1;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst = 1'b1;
        run = 1'b0;
        model_reset();
        step_cycle();
        step_cycle();
        rst = 1'b0;
    endtask

    task automatic clear_rom();
        for (int a = 0; a < (1 << AW); a++) rom_mem[a] = '0;
    endtask

    task automatic run_until(input int n, input int budget);
        int start, b;
        start = n_ret;
        b = 0;
        while ((n_ret - start) < n && b < budget) begin
            step_cycle();
            b++;
        end
        check("retire_count", 32'(n_ret - start), 32'(n));
    endtask

    typedef struct packed {
        logic [4:0][IW-1:0] prog;
        logic [3:0]         n_ret;
        logic [DW-1:0]      w;
        logic               z;
        logic               c;
        logic [AW-1:0]      pc;
    } vec_t;

    vec_t vecs [NV];

    function automatic vec_t mk(input logic [IW-1:0] i0, input logic [IW-1:0] i1,
                                input logic [IW-1:0] i2, input logic [IW-1:0] i3,
                                input logic [IW-1:0] i4, input int n, input logic [DW-1:0] w,
                                input logic z, input logic c, input logic [AW-1:0] pc);
        vec_t v;
        v.prog[0] = i0; v.prog[1] = i1; v.prog[2] = i2; v.prog[3] = i3; v.prog[4] = i4;
        v.n_ret = 4'(n); v.w = w; v.z = z; v.c = c; v.pc = pc;
        return v;
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        int r0;
        clear_rom();
        model_reset();

        vecs[0] = mk(enc(1, 8'h05), enc(2, 8'h03), 0, 0, 0, 2, 8'h08, 0, 0, 8'h02);
        vecs[1] = mk(enc(1, 8'hFF), enc(2, 8'h01), enc(8, 0), enc(1, 8'h77), enc(1, 8'h33),
                     4, 8'h33, 1, 1, 8'h05);
        vecs[2] = mk(enc(1, 8'h10), enc(3, 8'h08), 0, 0, 0, 2, 8'hF8, 0, 0, 8'h02);
        vecs[3] = mk(enc(1, 8'h08), enc(3, 8'h10), 0, 0, 0, 2, 8'h08, 0, 1, 8'h02);
        vecs[4] = mk(enc(1, 8'hF0), enc(4, 8'h0F), 0, 0, 0, 2, 8'h00, 1, 0, 8'h02);
        vecs[5] = mk(enc(1, 8'hF0), enc(5, 8'h0F), 0, 0, 0, 2, 8'hFF, 0, 0, 8'h02);
        vecs[6] = mk(enc(1, 8'hAA), enc(6, 8'hAA), 0, 0, 0, 2, 8'h00, 1, 0, 8'h02);
        vecs[7] = mk(enc(1, 8'h05), enc(3, 8'h05), 0, 0, 0, 2, 8'h00, 1, 1, 8'h02);
        vecs[8] = mk(enc(1, 8'h03), enc(8, 0), enc(1, 8'h44), 0, 0, 3, 8'h44, 0, 0, 8'h03);
        vecs[9] = mk(enc(2, 8'h80), enc(2, 8'h80), 0, 0, 0, 2, 8'h00, 1, 1, 8'h02);

        // Reset state.
        do_reset();
        check("reset_state", 32'(pack(w_q, z_flag, c_flag, pc_q, halted, err)), 32'(0));
        check("reset_retire", 32'(retire), 32'(0));

        // Table-driven programs.
        for (int i = 0; i < NV; i++) begin
            do_reset();
            clear_rom();
            for (int j = 0; j < 5; j++) rom_mem[j] = vecs[i].prog[j];
            run = 1'b1;
            run_until(int'(vecs[i].n_ret), 40);
            check($sformatf("vec%0d_spacing", i), 32'(ret_cyc_last - ret_cyc_prev), 32'(3));
            step_cycle();
            check($sformatf("vec%0d_w", i), 32'(w_q), 32'(vecs[i].w));
            check($sformatf("vec%0d_z", i), 32'(z_flag), 32'(vecs[i].z));
            check($sformatf("vec%0d_c", i), 32'(c_flag), 32'(vecs[i].c));
            check($sformatf("vec%0d_pc", i), 32'(pc_q), 32'(vecs[i].pc));
        end

        // GOTO to the last address, then wrap to 0.
        do_reset();
        clear_rom();
        rom_mem[0]   = enc(7, 8'hFF);
        rom_mem[255] = enc(2, 8'h01);
        run = 1'b1;
        run_until(2, 20);
        step_cycle();
        check("wrap_pc", 32'(pc_q), 32'(0));
        check("wrap_w", 32'(w_q), 32'(1));
        run_until(1, 10);

        // GOTO to its own address is a tight loop.
        do_reset();
        clear_rom();
        rom_mem[1] = enc(7, 8'h01);
        run = 1'b1;
        run_until(5, 40);
        step_cycle();
        check("loop_pc", 32'(pc_q), 32'(1));

        // HALT opcode: stops, no error, ignores run.
        do_reset();
        clear_rom();
        rom_mem[0] = enc(1, 8'h11);
        rom_mem[1] = enc(9, 0);
        rom_mem[2] = enc(1, 8'h22);
        run = 1'b1;
        run_until(2, 20);
        r0 = n_ret;
        repeat (8) step_cycle();
        check("halt_no_retire", 32'(n_ret - r0), 32'(0));
        check("halt_halted", 32'(halted), 32'(1));
        check("halt_err", 32'(err), 32'(0));
        check("halt_w", 32'(w_q), 32'(8'h11));

        // Illegal opcode: sticky error, halted, state frozen, then reset clears all.
        do_reset();
        clear_rom();
        rom_mem[0] = enc(2, 8'hFF);
        rom_mem[1] = enc(2, 8'h01);
        rom_mem[2] = enc(1, 8'h42);
        rom_mem[3] = enc(6'h3F, 8'h00);
        run = 1'b1;
        run_until(4, 30);
        step_cycle();
        check("ill_err", 32'(err), 32'(1));
        check("ill_halted", 32'(halted), 32'(1));
        check("ill_w", 32'(w_q), 32'(8'h42));
        r0 = n_ret;
        for (int t = 0; t < 12; t++) begin
            run = 1'($urandom_range(0, 1));
            step_cycle();
        end
        check("ill_no_retire", 32'(n_ret - r0), 32'(0));
        check("ill_frozen", 32'(pack(w_q, z_flag, c_flag, pc_q, halted, err)),
              32'(pack(8'h42, 1'b1, 1'b1, 8'h04, 1'b1, 1'b1)));
        rst = 1'b1;
        model_reset();
        step_cycle();
        check("ill_reset_state", 32'(pack(w_q, z_flag, c_flag, pc_q, halted, err)), 32'(0));
        check("ill_reset_retire", 32'(retire), 32'(0));
        check("ill_reset_addr", 32'(rom_bus.rom_addr), 32'(0));
        rst = 1'b0;

        // Reset during DECODE of ADDLW discards it.
        do_reset();
        clear_rom();
        rom_mem[0] = enc(1, 8'h3C);
        rom_mem[1] = enc(2, 8'h01);
        run = 1'b1;
        run_until(1, 10);
        step_cycle();
        step_cycle();
        check("mid_w_before", 32'(w_q), 32'(8'h3C));
        rst = 1'b1;
        model_reset();
        step_cycle();
        check("mid_w_after", 32'(w_q), 32'(0));
        check("mid_pc_after", 32'(pc_q), 32'(0));
        check("mid_retire_after", 32'(retire), 32'(0));
        rst = 1'b0;
        run = 1'b0;
        r0 = n_ret;
        repeat (6) step_cycle();
        check("idle_no_retire", 32'(n_ret - r0), 32'(0));
        check("idle_pc", 32'(pc_q), 32'(0));

        // Randomized program with run toggling, checked by the model.
        do_reset();
        for (int a = 0; a < (1 << AW); a++)
            rom_mem[a] = enc(6'($urandom_range(0, 8)), 8'($urandom_range(0, 255)));
        r0 = n_ret;
        for (int t = 0; t < 3000; t++) begin
            run = ($urandom_range(0, 7) != 0);
            step_cycle();
        end
        check("random_progress", 32'((n_ret - r0) >= 300), 32'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
